// File: rtl/mem_req_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_responder
//  Purpose  : Responder for the CPU instruction/data request handshake.
//             Arbitrates the I and D requesters onto one single-ported RAM
//             (data has priority), waits for ram_rdy, captures load data and
//             returns exactly one registered hit pulse per completed access.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK       in   1   clock, rising edge
//    nRST      in   1   asynchronous active-low reset
//    iREN      in   1   instruction read request (level, held until ihit)
//    iaddr     in   AW  instruction byte address
//    dREN      in   1   data read request (level, held until dhit)
//    dWEN      in   1   data write request (level, held until dhit)
//    daddr     in   AW  data byte address
//    dstore    in   DW  data write value
//    ihit      out  1   one-cycle pulse, instruction access complete
//    dhit      out  1   one-cycle pulse, data access complete
//    iload     out  DW  instruction word, held until next I completion
//    dload     out  DW  data read word, held until next D read completion
//    ramREN    out  1   RAM read enable   (registered)
//    ramWEN    out  1   RAM write enable  (registered)
//    ramaddr   out  AW  RAM address       (registered)
//    ramstore  out  DW  RAM write data    (registered)
//    ramload   in   DW  RAM read data, valid with ram_rdy
//    ram_rdy   in   1   RAM access completes this cycle
//    err       out  1   sticky timeout-abort flag, cleared only by reset
// ============================================================================
module mem_req_responder #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          ihit,
  output logic          dhit,
  output logic [DW-1:0] iload,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic          ram_rdy,
  output logic          err
);

  // Wait counter only needs to reach TIMEOUT-1; keep at least one bit so a
  // disabled timeout (TIMEOUT=0) still elaborates cleanly.
  localparam int unsigned   CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic          TO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DACC = 2'd1,
    S_IACC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          state_q,    state_d;
  logic            ihit_q,     ihit_d;
  logic            dhit_q,     dhit_d;
  logic [DW-1:0]   iload_q,    iload_d;
  logic [DW-1:0]   dload_q,    dload_d;
  logic            ramren_q,   ramren_d;
  logic            ramwen_q,   ramwen_d;
  logic [AW-1:0]   ramaddr_q,  ramaddr_d;
  logic [DW-1:0]   ramstore_q, ramstore_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic            err_q,      err_d;

  logic            dreq;
  logic            owner_req;
  logic            timeout_hit;

  assign dreq = dREN | dWEN;

  // The request that launched the in-flight access; dropping it aborts.
  assign owner_req = (state_q == S_DACC) ? dreq : iREN;

  // Counter holds the number of ram_rdy-less cycles already spent in the
  // access state, so this fires on the TIMEOUT-th waiting edge.
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    iload_d    = iload_q;
    dload_d    = dload_q;
    ramren_d   = ramren_q;
    ramwen_d   = ramwen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (dreq) begin
          // Data beats instruction; a simultaneous read+write is a write.
          state_d    = S_DACC;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          ramwen_d   = dWEN;
          ramren_d   = dREN & ~dWEN;
          cnt_d      = '0;
        end else if (iREN) begin
          state_d    = S_IACC;
          ramaddr_d  = iaddr;
          ramren_d   = 1'b1;
          ramwen_d   = 1'b0;
          cnt_d      = '0;
        end
      end

      S_DACC, S_IACC: begin
        if (!owner_req) begin
          // Requester withdrew: drop the access silently.
          state_d  = S_IDLE;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
        end else if (ram_rdy) begin
          // Completion takes precedence over a coincident timeout.
          state_d  = S_RESP;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
          if (state_q == S_DACC) begin
            dhit_d = 1'b1;
            if (ramren_q) begin
              dload_d = ramload;
            end
          end else begin
            ihit_d  = 1'b1;
            iload_d = ramload;
          end
        end else if (timeout_hit) begin
          state_d  = S_IDLE;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
          err_d    = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Hit is visible during this state; requests still asserted here
      // belong to the access just completed and are deliberately ignored.
      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        ramren_d = 1'b0;
        ramwen_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      ramren_q   <= ramren_d;
      ramwen_q   <= ramwen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign err      = err_q;

endmodule
`default_nettype wire
